board_io_bridge: RTL and testbench
==================================

# board_io_bridge

Synthesizable, parametrised bridge between a host-side emulator link and a board-style DUT (switches, keys, LEDs, 7-segment digits). It accepts input-state words over a valid/ready channel and drives them onto SW/KEY. After a programmable settle time it samples LED/HEX into an output-state frame and returns it over a second valid/ready channel. It can also report unsolicited output changes (watch mode). It sits between the emulator transport and the unit under test, replacing the untimed combinational state-update path.

## Interface
- N_SW, 10, switch count
- N_KEY, 4, key count
- N_LED, 10, LED count
- N_HEX, 6, 7-segment digit count (7 bits each)
- SETTLE_CYCLES, 2, cycles to wait after applying inputs before sampling outputs (0..255)
- Derived: IN_W = N_SW+N_KEY (default 14); OUT_W = N_LED+7*N_HEX (default 52)

Ports:
- CLK  in  1  sole clock, rising edge
- RST_N  in  1  reset, synchronous, active-low
- in_valid  in  1  host input word valid
- in_ready  out  1  bridge can accept input word
- in_data  in  IN_W  [N_SW-1:0]=SW, [IN_W-1:N_SW]=KEY
- out_valid  out  1  output frame valid
- out_ready  in  1  host accepts frame
- out_data  out  OUT_W  [N_LED-1:0]=LED, then HEX0..HEX(N_HEX-1), 7 bits each, ascending
- out_kind  out  1  0=RESP (answer to input word), 1=EVENT (unsolicited change)
- out_seq  out  8  frame sequence number
- watch_en  in  1  enable EVENT frames
- SW  out  N_SW  to DUT
- KEY  out  N_KEY  to DUT
- LED  in  N_LED  from DUT
- HEX  in  7*N_HEX  from DUT, HEX0 in bits [6:0]

## Operation
- States: IDLE, SETTLE, SEND.
- Reset (RST_N=0 at an edge) forces all of the following, regardless of state, including mid-SETTLE or mid-SEND:
  - state=IDLE
  - SW=0, KEY=0
  - out_valid=0, out_data=0, out_kind=0, out_seq=0
  - settle counter=0
  - last-reported snapshot=0
- in_ready = (state==IDLE). It is a pure decode of the state register, with no combinational path from in_valid.
- IDLE, in_valid=1: accept. SW/KEY are loaded from in_data at that edge, the counter is loaded with SETTLE_CYCLES, and state goes to SETTLE.
- IDLE, in_valid=0, watch_en=1, {HEX,LED} differs from snapshot: capture {HEX,LED} into out_data, set out_kind=1, set out_valid=1, update the snapshot, and go to SEND.
- Both conditions in the same IDLE cycle: the input word wins, and no EVENT frame is produced. Any change is carried by the subsequent RESP.
- SETTLE, counter≠0: decrement the counter.
- SETTLE, counter==0: capture {HEX,LED}, set out_kind=0, set out_valid=1, update the snapshot, and go to SEND.
- SEND: out_data, out_kind and out_seq are held stable while out_valid=1 and out_ready=0. On an edge with out_valid & out_ready: out_valid=0, out_seq increments (modulo 256, 255→0), and state goes to IDLE.
- SW/KEY hold their last accepted value until the next accepted word or reset. LED/HEX changes during SEND are not reported until IDLE is re-entered.
- watch_en=0 suppresses EVENT frames only. The snapshot is still updated by RESP captures.
- Out-of-range SETTLE_CYCLES (>255) is a parameter error, enforced by an elaboration-time check.

## Timing
- Accept at edge k: SW/KEY are valid after edge k. The capture edge is k+SETTLE_CYCLES+1, and out_valid is high from that edge.
  - SETTLE_CYCLES=0: out_valid is high after edge k+1.
  - Default 2: out_valid is high after edge k+3.
- Change detection: a LED/HEX difference present in IDLE before edge m yields out_valid high after edge m. This is 1-cycle latency, because the comparison is against the registered snapshot.
- Handshake completion at edge j: in_ready=1 after edge j. A back-to-back in_valid is accepted at edge j+1.
- Minimum RESP turnaround is SETTLE_CYCLES+3 cycles per word with out_ready tied high.
- LED/HEX are treated as synchronous to CLK; no synchronizers are inside this block.

## Structure
- Package board_io_pkg:
  - default counts N_SW/N_KEY/N_LED/N_HEX
  - state enum {IDLE, SETTLE, SEND}
  - out_kind constants KIND_RESP=0, KIND_EVENT=1
  - width helper functions for IN_W/OUT_W
- Sub-module io_snapshot:
  - Holds the OUT_W-bit last-reported register, with a load strobe and a synchronous active-low clear.
  - Outputs the combinational "changed" flag.
- The top level holds the FSM, settle counter, SW/KEY registers, sequence counter and output frame registers.

## Test plan
- Reset mid-SETTLE (SETTLE_CYCLES=4, RST_N low 1 cycle at count 2) -> SW=0, KEY=0, out_valid never asserts, in_ready=1 after the reset edge, out_seq=0.
- Default params, in_data=14'h2A5 accepted at edge k, DUT LED=SW -> out_valid first high after edge k+3, out_data[9:0]=10'h2A5, out_kind=0, out_seq=0.
- out_ready held low 10 cycles while LED toggles -> out_data/out_kind/out_seq stable; in_ready=0 throughout; after handshake, out_seq=1.
- watch_en=1, idle, LED changes 0→10'h001 -> EVENT frame after 1 edge with out_kind=1; LED unchanged afterwards -> no further frames.
- In IDLE, in_valid and an LED change in the same cycle -> only a RESP frame is produced, with out_kind=0; no EVENT frame follows unless LED changes again.
- 256 back-to-back RESP transactions with out_ready=1 -> out_seq runs 0..255 then wraps to 0; each turnaround is exactly SETTLE_CYCLES+3 cycles; SETTLE_CYCLES=0 build gives out_valid after k+1.

Source files
------------

// File: rtl/board_io_bridge_pkg.sv
// Shared defaults, FSM state type, frame-kind codes and width helpers for the
// board I/O bridge.
package board_io_pkg;

   localparam int DEF_N_SW  = 10;
   localparam int DEF_N_KEY = 4;
   localparam int DEF_N_LED = 10;
   localparam int DEF_N_HEX = 6;
   localparam int SEG_W     = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SEND   = 2'd2
   } state_e;

   localparam logic KIND_RESP  = 1'b0;
   localparam logic KIND_EVENT = 1'b1;

   function automatic int in_width(input int n_sw, input int n_key);
      return n_sw + n_key;
   endfunction

   function automatic int out_width(input int n_led, input int n_hex);
      return n_led + SEG_W * n_hex;
   endfunction

endpackage

// File: rtl/board_io_bridge_snapshot.sv
// Last-reported {HEX,LED} register; flags when the live outputs differ from
// what the host was last told.
module io_snapshot
   import board_io_pkg::*;
#(
   parameter int W = out_width(DEF_N_LED, DEF_N_HEX)
) (
   input  logic         i_clk,
   input  logic         i_clr_n,
   input  logic         i_load,
   input  logic [W-1:0] i_data,
   output logic         o_changed
);

   logic [W-1:0] r_snap;

   always_ff @(posedge i_clk) begin
      if (!i_clr_n)
         r_snap <= '0;
      else if (i_load)
         r_snap <= i_data;
   end

   assign o_changed = (i_data != r_snap);

endmodule

// File: rtl/board_io_bridge.sv
// Bridge from a host valid/ready link to board-style SW/KEY/LED/HEX: applies
// input words, waits a settle time, returns sampled output frames.
module board_io_bridge
   import board_io_pkg::*;
#(
   parameter  int N_SW          = DEF_N_SW,
   parameter  int N_KEY         = DEF_N_KEY,
   parameter  int N_LED         = DEF_N_LED,
   parameter  int N_HEX         = DEF_N_HEX,
   parameter  int SETTLE_CYCLES = 2,
   localparam int IN_W          = in_width(N_SW, N_KEY),
   localparam int OUT_W         = out_width(N_LED, N_HEX)
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IN_W-1:0]        in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_kind,
   output logic [7:0]             out_seq,
   input  logic                   watch_en,
   output logic [N_SW-1:0]        SW,
   output logic [N_KEY-1:0]       KEY,
   input  logic [N_LED-1:0]       LED,
   input  logic [SEG_W*N_HEX-1:0] HEX
);

   if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("board_io_bridge: SETTLE_CYCLES must be within 0..255");
   end

   localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

   state_e             r_state;
   logic [7:0]         r_cnt;
   logic [N_SW-1:0]    r_sw;
   logic [N_KEY-1:0]   r_key;
   logic               r_out_valid;
   logic               r_out_kind;
   logic [OUT_W-1:0]   r_out_data;
   logic [7:0]         r_seq;

   logic [OUT_W-1:0]   w_obs;
   logic               w_changed;
   logic               w_event;
   logic               w_capture;
   logic               w_snap_load;

   assign w_obs       = {HEX, LED};
   // An accepted input word always beats a pending change in the same cycle.
   assign w_event     = (r_state == IDLE) && !in_valid && watch_en && w_changed;
   assign w_capture   = (r_state == SETTLE) && (r_cnt == 8'd0);
   assign w_snap_load = w_event || w_capture;

   io_snapshot #(.W(OUT_W)) u_snap (
      .i_clk     (CLK),
      .i_clr_n   (RST_N),
      .i_load    (w_snap_load),
      .i_data    (w_obs),
      .o_changed (w_changed)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_sw        <= '0;
         r_key       <= '0;
         r_out_valid <= 1'b0;
         r_out_kind  <= KIND_RESP;
         r_out_data  <= '0;
         r_seq       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_sw    <= in_data[N_SW-1:0];
                  r_key   <= in_data[IN_W-1:N_SW];
                  r_cnt   <= SETTLE_LD;
                  r_state <= SETTLE;
               end else if (w_event) begin
                  r_out_data  <= w_obs;
                  r_out_kind  <= KIND_EVENT;
                  r_out_valid <= 1'b1;
                  r_state     <= SEND;
               end
            end
            SETTLE: begin
               if (r_cnt != 8'd0) begin
                  r_cnt <= r_cnt - 8'd1;
               end else begin
                  r_out_data  <= w_obs;
                  r_out_kind  <= KIND_RESP;
                  r_out_valid <= 1'b1;
                  r_state     <= SEND;
               end
            end
            SEND: begin
               if (r_out_valid && out_ready) begin
                  r_out_valid <= 1'b0;
                  r_seq       <= r_seq + 8'd1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_kind  = r_out_kind;
   assign out_seq   = r_seq;
   assign SW        = r_sw;
   assign KEY       = r_key;

endmodule

// File: tb/tb_board_io_bridge.sv
// Randomized self-checking bench for board_io_bridge against a transaction-level
// model (expected frames, sequence numbers and latencies from the protocol rules).
module tb_board_io_bridge;

   localparam int N_SW   = 10;
   localparam int N_KEY  = 4;
   localparam int N_LED  = 10;
   localparam int N_HEX  = 6;
   localparam int IN_W   = 14;
   localparam int OUT_W  = 52;
   localparam int SETTLE = 2;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic               RST_N;
   logic               in_valid, in_ready, out_valid, out_ready, out_kind, watch_en;
   logic [IN_W-1:0]    in_data;
   logic [OUT_W-1:0]   out_data;
   logic [7:0]         out_seq;
   logic [N_SW-1:0]    SW;
   logic [N_KEY-1:0]   KEY;
   logic [N_LED-1:0]   LED, led_drv;
   logic [7*N_HEX-1:0] HEX, hex_drv;
   logic               led_mode;

   // board model: LEDs either mirror the switches or are driven directly
   assign LED = led_mode ? SW : led_drv;
   assign HEX = hex_drv;

   board_io_bridge #(.SETTLE_CYCLES(SETTLE)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_kind(out_kind), .out_seq(out_seq),
      .watch_en(watch_en), .SW(SW), .KEY(KEY), .LED(LED), .HEX(HEX)
   );

   logic               in_valid_z, in_ready_z, out_valid_z, out_kind_z;
   logic [IN_W-1:0]    in_data_z;
   logic [OUT_W-1:0]   out_data_z;
   logic [7:0]         out_seq_z;
   logic [N_SW-1:0]    SW_z;
   logic [N_KEY-1:0]   KEY_z;
   logic [N_LED-1:0]   LED_z;
   logic [7*N_HEX-1:0] HEX_z;

   assign LED_z = SW_z;
   assign HEX_z = '0;

   board_io_bridge #(.SETTLE_CYCLES(0)) u_dut0 (
      .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid_z), .in_ready(in_ready_z),
      .in_data(in_data_z), .out_valid(out_valid_z), .out_ready(1'b1),
      .out_data(out_data_z), .out_kind(out_kind_z), .out_seq(out_seq_z),
      .watch_en(1'b0), .SW(SW_z), .KEY(KEY_z), .LED(LED_z), .HEX(HEX_z)
   );

   int               n_chk = 0;
   int               n_fail = 0;
   int               exp_seq;
   logic [OUT_W-1:0] snap;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [OUT_W-1:0] rand_obs();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[OUT_W-1:0];
   endfunction

   task automatic do_reset();
      RST_N = 1'b0; in_valid = 1'b0; out_ready = 1'b0; watch_en = 1'b0;
      led_drv = '0; hex_drv = '0; led_mode = 1'b0;
      tick(); tick();
      RST_N = 1'b1;
      exp_seq = 0;
      snap = '0;
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      while (!out_valid && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic handshake(input logic [OUT_W-1:0] frame);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hs_valid", 64'(out_valid), 64'(0));
      check("hs_ready", 64'(in_ready), 64'(1));
      exp_seq = (exp_seq + 1) % 256;
      snap = frame;
   endtask

   task automatic do_resp(input logic [IN_W-1:0] d, input logic [OUT_W-1:0] obs,
                          input int hold, input logic we);
      logic [OUT_W-1:0] frame;
      int n;
      check("resp_ready", 64'(in_ready), 64'(1));
      watch_en = we;
      in_valid = 1'b1;
      in_data  = d;
      if (!led_mode) {hex_drv, led_drv} = obs;
      tick();
      in_valid = 1'b0;
      check("sw", 64'(SW), 64'(d[N_SW-1:0]));
      check("key", 64'(KEY), 64'(d[IN_W-1:N_SW]));
      check("busy", 64'(in_ready), 64'(0));
      frame = led_mode ? {hex_drv, d[N_SW-1:0]} : obs;
      wait_valid(20, n);
      check("resp_latency", 64'(n), 64'(SETTLE + 1));
      check("resp_data", 64'(out_data), 64'(frame));
      check("resp_kind", 64'(out_kind), 64'(0));
      check("resp_seq", 64'(out_seq), 64'(exp_seq));
      for (int i = 0; i < hold; i++) begin
         led_drv = ~led_drv;
         hex_drv = hex_drv ^ 42'h1;
         tick();
         check("hold_valid", 64'(out_valid), 64'(1));
         check("hold_data", 64'(out_data), 64'(frame));
         check("hold_kind", 64'(out_kind), 64'(0));
         check("hold_seq", 64'(out_seq), 64'(exp_seq));
         check("hold_busy", 64'(in_ready), 64'(0));
      end
      if (led_mode) hex_drv = frame[OUT_W-1:N_LED];
      else {hex_drv, led_drv} = obs;
      handshake(frame);
   endtask

   task automatic do_event(input logic [OUT_W-1:0] obs);
      check("ev_ready", 64'(in_ready), 64'(1));
      watch_en = 1'b1;
      {hex_drv, led_drv} = obs;
      check("ev_pre", 64'(out_valid), 64'(0));
      tick();
      check("ev_valid", 64'(out_valid), 64'(1));
      check("ev_kind", 64'(out_kind), 64'(1));
      check("ev_data", 64'(out_data), 64'(obs));
      check("ev_seq", 64'(out_seq), 64'(exp_seq));
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
         tick();
         check("ev_hold", 64'(out_data), 64'(obs));
      end
      handshake(obs);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ev_quiet", 64'(out_valid), 64'(0));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [OUT_W-1:0] obs;
      logic [IN_W-1:0]  qd;
      logic [IN_W-1:0]  q[$];
      int n, frames, cyc, last;
      logic acc;

      in_valid_z = 1'b0; in_data_z = '0; in_data = '0;
      do_reset();
      check("rst_ready", 64'(in_ready), 64'(1));
      check("rst_sw", 64'(SW), 64'(0));
      check("rst_key", 64'(KEY), 64'(0));
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_data", 64'(out_data), 64'(0));
      check("rst_kind", 64'(out_kind), 64'(0));
      check("rst_seq", 64'(out_seq), 64'(0));

      // zero-settle build: frame after one edge past the accept
      for (int i = 0; i < 3; i++) begin
         qd = 14'($urandom);
         in_valid_z = 1'b1; in_data_z = qd;
         tick();
         in_valid_z = 1'b0;
         check("z_key", 64'(KEY_z), 64'(qd[IN_W-1:N_SW]));
         check("z_early", 64'(out_valid_z), 64'(0));
         tick();
         check("z_valid", 64'(out_valid_z), 64'(1));
         check("z_data", 64'(out_data_z), 64'({42'h0, qd[N_SW-1:0]}));
         check("z_kind", 64'(out_kind_z), 64'(0));
         check("z_seq", 64'(out_seq_z), 64'(i));
         tick();
         check("z_done", 64'(out_valid_z), 64'(0));
         check("z_ready", 64'(in_ready_z), 64'(1));
      end

      led_mode = 1'b1;
      do_resp(14'h2A5, '0, 0, 1'b0);
      led_mode = 1'b0;
      do_resp(14'($urandom), rand_obs(), 10, 1'b0);

      do_reset();
      do_event(52'h1);

      obs = snap ^ 52'h2;
      do_resp(14'($urandom), obs, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("same_quiet", 64'(out_valid), 64'(0));
      end

      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            obs = rand_obs();
            while (obs == snap) obs = rand_obs();
            do_event(obs);
         end else begin
            do_resp(14'($urandom), rand_obs(), int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)));
         end
         check("idle_ready", 64'(in_ready), 64'(1));
         check("idle_valid", 64'(out_valid), 64'(0));
      end

      // reset in the middle of the settle window
      watch_en = 1'b0;
      in_valid = 1'b1; in_data = 14'h3FFF;
      tick();
      in_valid = 1'b0;
      tick();
      RST_N = 1'b0; led_drv = '0; hex_drv = '0;
      tick();
      RST_N = 1'b1; exp_seq = 0; snap = '0;
      check("rs_sw", 64'(SW), 64'(0));
      check("rs_key", 64'(KEY), 64'(0));
      check("rs_ready", 64'(in_ready), 64'(1));
      check("rs_seq", 64'(out_seq), 64'(0));
      for (int i = 0; i < 6; i++) begin
         tick();
         check("rs_novalid", 64'(out_valid), 64'(0));
      end

      // reset while a frame is waiting for the host
      do_resp(14'($urandom), rand_obs() | 52'h1, 0, 1'b0);
      in_valid = 1'b1; in_data = 14'($urandom);
      {hex_drv, led_drv} = rand_obs() | 52'h1;
      tick();
      in_valid = 1'b0;
      wait_valid(20, n);
      check("rsend_pre", 64'(out_valid), 64'(1));
      RST_N = 1'b0; led_drv = '0; hex_drv = '0;
      tick();
      RST_N = 1'b1; exp_seq = 0; snap = '0;
      check("rsend_valid", 64'(out_valid), 64'(0));
      check("rsend_data", 64'(out_data), 64'(0));
      check("rsend_kind", 64'(out_kind), 64'(0));
      check("rsend_seq", 64'(out_seq), 64'(0));
      check("rsend_ready", 64'(in_ready), 64'(1));

      // back-to-back RESP stream: sequence wrap and fixed turnaround
      do_reset();
      led_mode = 1'b1;
      hex_drv = 42'({$urandom, $urandom});
      out_ready = 1'b1; in_valid = 1'b1; in_data = 14'($urandom);
      frames = 0; cyc = 0; last = -1;
      while (frames < 257 && cyc < 2000) begin
         acc = in_ready && in_valid;
         tick();
         cyc++;
         if (acc) begin
            q.push_back(in_data);
            in_data = 14'($urandom);
         end
         if (out_valid) begin
            if (q.size() == 0) qd = '0;
            else qd = q.pop_front();
            check("b2b_data", 64'(out_data), 64'({hex_drv, qd[N_SW-1:0]}));
            check("b2b_kind", 64'(out_kind), 64'(0));
            check("b2b_seq", 64'(out_seq), 64'(exp_seq));
            if (last >= 0) check("b2b_period", 64'(cyc - last), 64'(SETTLE + 3));
            last = cyc;
            exp_seq = (exp_seq + 1) % 256;
            frames++;
            if (frames == 257) in_valid = 1'b0;
         end
      end
      check("b2b_frames", 64'(frames), 64'(257));
      tick();
      out_ready = 1'b0;
      check("b2b_end_ready", 64'(in_ready), 64'(1));
      check("b2b_end_seq", 64'(out_seq), 64'(exp_seq));

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
